speed_pulse_counter: RTL and testbench

- Measurement stage directly downstream of the D flip-flop synchroniser chain on the wheel-sensor input.
- Takes the synchronised pulse (final flip-flop Q), detects rising edges, and counts them over a fixed gate window of clock cycles.
- At the end of each window it publishes the count as a speed value with a one-cycle valid strobe and an over-speed flag.
- Its outputs feed the speed control logic.

---
 rtl/speed_pulse_counter.sv | 84 ++++++++
 tb/tb_speed_pulse_counter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/speed_pulse_counter.sv
// speed_pulse_counter: counts rising edges of the synchronised wheel pulse over a fixed gate window and publishes speed, over-speed and saturation; define OVERSPEED_HYST_EN for over-speed hysteresis
module speed_pulse_counter #(
  parameter int CNT_W       = 8,
  parameter int GATE_CYCLES = 1000,
  parameter int SPEED_LIMIT = 60,
  parameter int HYST        = 4
) (
  input  logic             CLK,
  input  logic             CLR_BAR,
  input  logic             PULSE_Q,
  input  logic             ENABLE,
  output logic [CNT_W-1:0] SPEED,
  output logic             SPEED_VALID,
  output logic             OVERSPEED,
  output logic             SATURATED
);
  localparam int TW = $clog2(GATE_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(SPEED_LIMIT);
  if (GATE_CYCLES < 2 || HYST > SPEED_LIMIT) begin : g_bad_params
    $error("speed_pulse_counter: GATE_CYCLES must be >= 2 and HYST <= SPEED_LIMIT");
  end
  typedef enum logic [1:0] {IDLE, COUNT, LATCH} state_t;
  state_t           state;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] count;
  logic             prev;
  logic             rise;
  logic             over_next;
  assign rise = PULSE_Q & ~prev;
`ifdef OVERSPEED_HYST_EN
  localparam logic [CNT_W-1:0] LOW = LIM - CNT_W'(HYST);
  // over-speed sets above the limit, clears only below the hysteresis band, holds in between
  always_comb over_next = (count > LIM) ? 1'b1 : (count < LOW) ? 1'b0 : OVERSPEED;
`else
  // over-speed follows the latched count directly
  always_comb over_next = count > LIM;
`endif
  // window sequencer: counts edges in COUNT, publishes in LATCH, carries a LATCH-cycle edge into the next window
  always_ff @(posedge CLK or negedge CLR_BAR) begin
    if (!CLR_BAR) begin
      state       <= IDLE;
      timer       <= '0;
      count       <= '0;
      prev        <= 1'b1;
      SPEED       <= '0;
      SPEED_VALID <= 1'b0;
      OVERSPEED   <= 1'b0;
      SATURATED   <= 1'b0;
    end else begin
      prev        <= PULSE_Q;
      SPEED_VALID <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          count <= '0;
          if (ENABLE) state <= COUNT;
        end
        COUNT: begin
          if (!ENABLE) begin
            state <= IDLE;
            timer <= '0;
            count <= '0;
          end else begin
            if (rise && count != MAX) count <= count + 1'b1;
            if (timer == LAST) state <= LATCH;
            else timer <= timer + 1'b1;
          end
        end
        LATCH: begin
          SPEED       <= count;
          SPEED_VALID <= 1'b1;
          SATURATED   <= count == MAX;
          OVERSPEED   <= over_next;
          timer       <= '0;
          count       <= CNT_W'(rise);
          state       <= ENABLE ? COUNT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_speed_pulse_counter.sv
// tb_speed_pulse_counter: directed vector bench for speed_pulse_counter (16-cycle and 48-cycle windows)
module tb_speed_pulse_counter;
  logic       clk = 1'b0;
  logic       clr_bar = 1'b0;
  logic       pq = 1'b1;
  logic       en = 1'b0;
  logic       pb = 1'b0;
  logic       enb = 1'b0;
  logic [3:0] speed, speed_b;
  logic       valid, over, sat, valid_b, over_b, sat_b;
  int         total = 0;
  int         passed = 0;

  speed_pulse_counter #(.CNT_W(4), .GATE_CYCLES(16), .SPEED_LIMIT(10), .HYST(4)) dut_a (
    .CLK(clk), .CLR_BAR(clr_bar), .PULSE_Q(pq), .ENABLE(en),
    .SPEED(speed), .SPEED_VALID(valid), .OVERSPEED(over), .SATURATED(sat)
  );

  speed_pulse_counter #(.CNT_W(4), .GATE_CYCLES(48), .SPEED_LIMIT(10), .HYST(4)) dut_b (
    .CLK(clk), .CLR_BAR(clr_bar), .PULSE_Q(pb), .ENABLE(enb),
    .SPEED(speed_b), .SPEED_VALID(valid_b), .OVERSPEED(over_b), .SATURATED(sat_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] pat;
    int          speed;
  } va_t;

  typedef struct {
    int n;
    int speed;
    int sat;
    int over_def;
    int over_hyst;
  } vb_t;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // called in the first COUNT cycle; pat[i] drives PULSE_Q in window cycle i (16 = LATCH)
  task automatic win_a(input logic [16:0] pat, input int exp, input string name);
    int early = 0;
    for (int i = 0; i < 17; i++) begin
      pq = pat[i];
      if (i > 0 && valid) early++;
      tick();
    end
    chk({name, " early strobe"}, early, 0);
    chk({name, " valid"}, int'(valid), 1);
    chk({name, " speed"}, int'(speed), exp);
    chk({name, " overspeed"}, int'(over), (exp > 10) ? 1 : 0);
    chk({name, " saturated"}, int'(sat), 0);
  endtask

  task automatic win_b(input vb_t v, input string name);
    int early = 0;
    for (int i = 0; i < 49; i++) begin
      pb = (i % 2 == 1) && (i / 2 < v.n);
      if (i > 0 && valid_b) early++;
      tick();
    end
    chk({name, " early strobe"}, early, 0);
    chk({name, " valid"}, int'(valid_b), 1);
    chk({name, " speed"}, int'(speed_b), v.speed);
    chk({name, " saturated"}, int'(sat_b), v.sat);
`ifdef OVERSPEED_HYST_EN
    chk({name, " overspeed"}, int'(over_b), v.over_hyst);
`else
    chk({name, " overspeed"}, int'(over_b), v.over_def);
`endif
  endtask

  initial begin
    va_t tab_a[5];
    vb_t tab_b[10];
    int  strobes;
    tab_a[0] = '{17'h1FFFF, 0};
    tab_a[1] = '{17'h002AA, 5};
    tab_a[2] = '{17'h15555, 8};
    tab_a[3] = '{17'h0AAAA, 9};
    tab_a[4] = '{17'h002AA, 5};
    tab_b[0] = '{20, 15, 1, 1, 1};
    tab_b[1] = '{12, 12, 0, 1, 1};
    tab_b[2] = '{8, 8, 0, 0, 1};
    tab_b[3] = '{5, 5, 0, 0, 0};
    tab_b[4] = '{0, 0, 0, 0, 0};
    tab_b[5] = '{11, 11, 0, 1, 1};
    tab_b[6] = '{10, 10, 0, 0, 1};
    tab_b[7] = '{6, 6, 0, 0, 1};
    tab_b[8] = '{5, 5, 0, 0, 0};
    tab_b[9] = '{15, 15, 1, 1, 1};
    repeat (3) tick();
    chk("reset speed", int'(speed), 0);
    chk("reset valid", int'(valid), 0);
    chk("reset overspeed", int'(over), 0);
    chk("reset saturated", int'(sat), 0);
    clr_bar = 1'b1;
    en = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) win_a(tab_a[k].pat, tab_a[k].speed, $sformatf("winA%0d", k));
    for (int i = 0; i < 7; i++) begin
      pq = (i == 1 || i == 3);
      tick();
    end
    en = 1'b0;
    pq = 1'b0;
    tick();
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid) strobes++;
      tick();
    end
    chk("abort strobes", strobes, 0);
    chk("abort speed held", int'(speed), 5);
    chk("abort overspeed held", int'(over), 0);
    en = 1'b1;
    tick();
    win_a(17'h0002A, 3, "restart");
    repeat (3) tick();
    #3 clr_bar = 1'b0;
    #1;
    chk("async reset speed", int'(speed), 0);
    chk("async reset valid", int'(valid), 0);
    en = 1'b0;
    tick();
    clr_bar = 1'b1;
    enb = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) win_b(tab_b[k], $sformatf("winB%0d", k));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
